io_stall_controller: RTL and testbench
======================================

// Module: io_stall_controller
// PURPOSE
//  Sequences the PC-stalling instructions decoded by the control unit: in, out, halt.
//  Holds the PC while in waits for an operator enter press, and latches the switch value for register write-back.
//  Holds the display register stable for a fixed number of cycles on out, and freezes the core on halt.
//  Sits between the control unit (pcctrl/inctrl/outctrl) and the PC register / register-file write port.
// PARAMETERS
//  DATA_W    32  datapath width (indata, outdata, display)
//  SW_W      16  number of input switches, SW_W <= DATA_W
//  OUT_HOLD  4   cycles the PC stays frozen after an out is accepted, >= 1
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  pcctrl        in   1       control unit: 1 = PC may advance, 0 = stall request (in/out/halt)
//  inctrl        in   1       control unit: current instruction is in
//  outctrl       in   1       control unit: current instruction is out
//  sw            in   SW_W    raw switch inputs, quasi-static
//  enter_btn     in   1       raw operator button, asynchronous, active-high
//  outdata       in   DATA_W  register-file read data for out
//  pcen          out  1       PC write enable
//  indata        out  DATA_W  latched switch value, zero-extended, to regdatain mux input 000
//  in_wr         out  1       1-cycle register-file write qualifier for in
//  display       out  DATA_W  display register
//  halted        out  1       core frozen by halt
//  busy          out  1       FSM not in RUN
// BEHAVIOUR
//  Reset (async): state=RUN; indata=0; display=0; in_wr=0; halted=0; busy=0; counter=0; sync flops=0.
//  Button: 2-flop synchroniser, then a registered copy; press = synced & ~prev (1 clk pulse, 3-cycle latency).
//  States and transitions, evaluated on the rising edge of clk:
//   RUN:      pcen = pcctrl (combinational); in_wr=0.
//             inctrl=1 -> IN_WAIT. inctrl has priority if inctrl and outctrl are both 1 (illegal decode).
//             else outctrl=1 -> display<=outdata, counter<=OUT_HOLD-1, -> OUT_WAIT.
//             else pcctrl=0 -> HALTED.
//   IN_WAIT:  pcen=0. On press: indata<={0,sw}, -> IN_DONE.
//             A button already high on entry is not a press; a release and a new press are required.
//   IN_DONE:  pcen=1, in_wr=1 for exactly this cycle, -> RUN.
//   OUT_WAIT: pcen = (counter==0). counter!=0 -> counter-1. counter==0 -> RUN.
//             display is held constant for the whole state.
//   HALTED:   pcen=0, halted=1. Leaves only by rst. Presses, inctrl and outctrl are ignored.
//  busy = (state != RUN). display and indata keep their value until the next out or in.
//  Latency: the PC advances on the edge ending IN_DONE (in), or OUT_HOLD cycles after the accept cycle (out).
//  Counter width: clog2(OUT_HOLD)+1 bits. It never wraps because it is reloaded only from RUN.
//  Reset in any state returns to RUN in the same instant. A pending press is lost and in_wr drops immediately.
//  sw is sampled only on the press edge, with no synchroniser (quasi-static by usage).
// TESTING
//  T1 reset mid IN_WAIT: assert rst -> pcen=pcctrl, busy=0, indata=0 without waiting for a clock.
//  T2 in, sw=16'hBEEF, press after 10 cycles -> pcen=0 until press+3, then 1 cycle pcen=1 & in_wr=1, indata=32'h0000BEEF.
//  T3 in with enter_btn already held high -> no completion; release then press -> completes as T2.
//  T4 out, outdata=32'h12345678, OUT_HOLD=4 -> display=32'h12345678 next edge; pcen=0 for 4 cycles (incl. accept), 1 on the 5th.
//  T5 halt (pcctrl=0, inctrl=outctrl=0) -> halted=1, pcen=0 held for 100 cycles despite presses; rst clears it.
//  T6 inctrl=outctrl=1 together -> IN_WAIT is taken; display is unchanged.

Source files
------------

// File: rtl/io_stall_controller.sv
// Stall sequencer for the in/out/halt instructions: freezes the PC while waiting
// for the operator, holds the display for a fixed time, and freezes the core on halt.
//
// state      | meaning
// S_RUN      | normal execution, pcen follows the control unit
// S_IN_WAIT  | in decoded, PC frozen until a fresh enter press
// S_IN_DONE  | switch value latched, one-cycle register write and PC advance
// S_OUT_WAIT | display loaded, PC frozen until the hold counter expires
// S_HALTED   | core frozen, only reset leaves
module io_stall_controller #(
  parameter int DATA_W   = 32,
  parameter int SW_W     = 16,
  parameter int OUT_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcctrl,
  input  logic              inctrl,
  input  logic              outctrl,
  input  logic [SW_W-1:0]   sw,
  input  logic              enter_btn,
  input  logic [DATA_W-1:0] outdata,
  output logic              pcen,
  output logic [DATA_W-1:0] indata,
  output logic              in_wr,
  output logic [DATA_W-1:0] display,
  output logic              halted,
  output logic              busy
);

  localparam int CNT_W = $clog2(OUT_HOLD) + 1;

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_IN_WAIT  = 3'd1,
    S_IN_DONE  = 3'd2,
    S_OUT_WAIT = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  counter;
  logic              btn_s1, btn_s2, btn_prev;
  logic              press;
  logic              load_display, load_indata, load_cnt, dec_cnt;
  logic [DATA_W-1:0] sw_ext;

  // Edge detect after the synchroniser, so a button held across entry is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      btn_s1   <= enter_btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pcen         = 1'b0;
    in_wr        = 1'b0;
    load_display = 1'b0;
    load_indata  = 1'b0;
    load_cnt     = 1'b0;
    dec_cnt      = 1'b0;
    case (state)
      S_RUN: begin
        pcen = pcctrl;
        if (inctrl) begin
          state_nxt = S_IN_WAIT;
        end else if (outctrl) begin
          load_display = 1'b1;
          load_cnt     = 1'b1;
          state_nxt    = S_OUT_WAIT;
        end else if (!pcctrl) begin
          state_nxt = S_HALTED;
        end
      end
      S_IN_WAIT: begin
        if (press) begin
          load_indata = 1'b1;
          state_nxt   = S_IN_DONE;
        end
      end
      S_IN_DONE: begin
        pcen      = 1'b1;
        in_wr     = 1'b1;
        state_nxt = S_RUN;
      end
      S_OUT_WAIT: begin
        if (counter == '0) begin
          pcen      = 1'b1;
          state_nxt = S_RUN;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      S_HALTED: begin
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  always_comb begin
    sw_ext           = '0;
    sw_ext[SW_W-1:0] = sw;
  end

  // Counter is reloaded only from RUN, so the decrement never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= '0;
      display <= '0;
      indata  <= '0;
    end else begin
      if (load_cnt)     counter <= CNT_W'(OUT_HOLD - 1);
      else if (dec_cnt) counter <= counter - 1'b1;
      if (load_display) display <= outdata;
      if (load_indata)  indata  <= sw_ext;
    end
  end

  assign halted = (state == S_HALTED);
  assign busy   = (state != S_RUN);

endmodule

// File: tb/tb_io_stall_controller.sv
// Directed bench for io_stall_controller: cycle vector table for out / illegal decode,
// plus hand sequences for in, button-held entry, async reset and halt.
module tb_io_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcctrl, inctrl, outctrl;
  logic [15:0] sw;
  logic        enter_btn;
  logic [31:0] outdata;
  logic        pcen, in_wr, halted, busy;
  logic [31:0] indata, display;

  int n_assert = 0;
  int n_fail   = 0;

  io_stall_controller #(.DATA_W(32), .SW_W(16), .OUT_HOLD(4)) dut (
    .clk(clk), .rst(rst), .pcctrl(pcctrl), .inctrl(inctrl), .outctrl(outctrl),
    .sw(sw), .enter_btn(enter_btn), .outdata(outdata), .pcen(pcen),
    .indata(indata), .in_wr(in_wr), .display(display), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pcctrl, inctrl, outctrl;
    logic [31:0] outdata;
    logic        e_pcen, e_busy, e_in_wr, e_halted;
    logic [31:0] e_display;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // accept out, hold 4 cycles, return to RUN, then illegal in+out decode
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h55555555, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vecs[9] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};

    rst = 1'b1; pcctrl = 1'b1; inctrl = 1'b0; outctrl = 1'b0;
    sw = 16'h0; enter_btn = 1'b0; outdata = 32'h0;
    #3;
    chk("rst_pcen", pcen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_indata", indata, 0);
    chk("rst_display", display, 0);
    chk("rst_in_wr", in_wr, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // T4 / T6 vector table
    for (int i = 0; i < 10; i++) begin
      pcctrl = vecs[i].pcctrl; inctrl = vecs[i].inctrl;
      outctrl = vecs[i].outctrl; outdata = vecs[i].outdata;
      #1;
      chk($sformatf("vec%0d_pcen", i), pcen, vecs[i].e_pcen);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_in_wr", i), in_wr, vecs[i].e_in_wr);
      chk($sformatf("vec%0d_halted", i), halted, vecs[i].e_halted);
      chk($sformatf("vec%0d_display", i), display, vecs[i].e_display);
      step();
    end

    // T2: still in IN_WAIT from the table; press arrives later
    sw = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_wait_pcen", pcen, 0);
      step();
    end
    enter_btn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2_sync_pcen", pcen, 0);
      chk("t2_sync_in_wr", in_wr, 0);
    end
    step();
    chk("t2_done_pcen", pcen, 1);
    chk("t2_done_in_wr", in_wr, 1);
    chk("t2_indata", indata, 32'h0000BEEF);
    chk("t2_done_busy", busy, 1);
    pcctrl = 1'b1; inctrl = 1'b0;
    step();
    chk("t2_after_in_wr", in_wr, 0);
    chk("t2_after_busy", busy, 0);
    chk("t2_after_pcen", pcen, 1);
    chk("t2_after_indata", indata, 32'h0000BEEF);
    enter_btn = 1'b0;

    // T3: button already held when in is decoded
    enter_btn = 1'b1; sw = 16'h1234;
    for (int i = 0; i < 4; i++) step();
    inctrl = 1'b1; pcctrl = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_held_in_wr", in_wr, 0);
      chk("t3_held_busy", busy, 1);
      chk("t3_held_pcen", pcen, 0);
      step();
    end
    enter_btn = 1'b0;
    for (int i = 0; i < 4; i++) step();
    enter_btn = 1'b1;
    cnt = 0;
    while (cnt < 8) begin
      step();
      cnt++;
      if (in_wr) break;
    end
    chk("t3_latency", cnt, 3);
    chk("t3_indata", indata, 32'h00001234);
    pcctrl = 1'b1; inctrl = 1'b0; enter_btn = 1'b0;
    step();
    chk("t3_after_busy", busy, 0);

    // T1: async reset in the middle of IN_WAIT
    inctrl = 1'b1; pcctrl = 1'b0;
    step();
    chk("t1_busy_before", busy, 1);
    pcctrl = 1'b1; inctrl = 1'b0;
    #1;
    chk("t1_pcen_before", pcen, 0);
    rst = 1'b1;
    #1;
    chk("t1_pcen", pcen, 1);
    chk("t1_busy", busy, 0);
    chk("t1_indata", indata, 0);
    chk("t1_in_wr", in_wr, 0);
    chk("t1_display", display, 0);
    #2;
    rst = 1'b0;
    step();

    // T5: halt ignores presses and decodes, only reset clears it
    pcctrl = 1'b0; inctrl = 1'b0; outctrl = 1'b0;
    step();
    for (int i = 0; i < 100; i++) begin
      enter_btn = ((i % 7) < 3);
      inctrl    = ((i % 5) == 0);
      outctrl   = ((i % 11) == 0);
      outdata   = 32'hC0DE0000 + i;
      #1;
      chk("t5_halted", halted, 1);
      chk("t5_pcen", pcen, 0);
      chk("t5_busy", busy, 1);
      chk("t5_display", display, 0);
      chk("t5_in_wr", in_wr, 0);
      step();
    end
    enter_btn = 1'b0; inctrl = 1'b0; outctrl = 1'b0; pcctrl = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_halted", halted, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pcen", pcen, 1);
    #2;
    rst = 1'b0;
    step();
    chk("t5_run_pcen", pcen, 1);
    chk("t5_run_halted", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
